// File: rtl/rr_arb8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter with encoded grant.
package rr_arb8_pkg;
  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb8_enc_pick.sv
// rr_pick8: rotating-priority pick of the first set request at or after ptr.
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // cand wraps naturally in IDX_W bits
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/rr_arb8_enc.sv
// Round-robin 8-way arbiter: IDLE -> OFFER -> BUSY, released by done.
// Optional accepted-grant counter enabled by RR_ARB_COUNT_EN.
module rr_arb8_enc
  import rr_arb8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             gnt_ready,
  input  logic             done,
  output logic             gnt_valid,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
`ifdef RR_ARB_COUNT_EN
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt
`else
  output logic             busy
`endif
);
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign gnt_valid = (state == OFFER);
  assign busy      = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= OFFER;
            gnt_onehot <= pick_oh;
            gnt_idx    <= pick_idx;
          end
        end
        OFFER: begin
          if (gnt_ready) state <= BUSY;
        end
        BUSY: begin
          if (done) begin
            state      <= IDLE;
            ptr        <= gnt_idx + IDX_W'(1);
            gnt_onehot <= '0;
            gnt_idx    <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          gnt_onehot <= '0;
          gnt_idx    <= '0;
        end
      endcase
    end
  end

`ifdef RR_ARB_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gnt_cnt <= '0;
    else if (state == OFFER && gnt_ready)
      gnt_cnt <= gnt_cnt + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_arb8_enc.sv
// Self-checking bench for rr_arb8_enc: vector table, corner sequences,
// then random traffic against a behavioural model.
module tb_rr_arb8_enc;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
  logic       done;
  logic       gnt_valid;
  logic [7:0] gnt_onehot;
  logic [2:0] gnt_idx;
  logic       busy;
`ifdef RR_ARB_COUNT_EN
  logic [15:0] gnt_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  rr_arb8_enc #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
`ifdef RR_ARB_COUNT_EN
    .busy       (busy),
    .gnt_cnt    (gnt_cnt)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       dn;
    logic       v;
    logic       b;
    logic [7:0] oh;
    logic [2:0] ix;
  } vec_t;

  vec_t tbl [11];

  // behavioural model
  int m_st;   // 0 idle, 1 offered, 2 held
  int m_ptr;
  int m_idx;
  int m_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(logic [7:0] r, logic rd, logic d);
    req       = r;
    gnt_ready = rd;
    done      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string name, logic v, logic b,
                         logic [7:0] oh, logic [2:0] ix);
    chk({name, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({name, ".busy"}, 32'(busy), 32'(b));
    chk({name, ".onehot"}, 32'(gnt_onehot), 32'(oh));
    chk({name, ".idx"}, 32'(gnt_idx), 32'(ix));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_st = 0;
    m_ptr = 0;
    m_idx = 0;
    m_cnt = 0;
  endtask

  function automatic int winner(logic [7:0] r, int p);
    for (int i = p; i < 8; i++) if (r[i]) return i;
    for (int i = 0; i < p; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_step(logic [7:0] r, logic rd, logic d);
    if (m_st == 0) begin
      if (r != 0) begin
        m_idx = winner(r, m_ptr);
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (rd) begin
        m_st = 2;
        m_cnt = (m_cnt + 1) % 65536;
      end
    end else if (d) begin
      m_ptr = (m_idx + 1) % 8;
      m_st = 0;
    end
  endtask

  initial begin
    tbl[0]  = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0};
    tbl[1]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[3]  = '{8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 3'd2};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 3'd2};
    tbl[5]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2};
    tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 3'd2};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[8]  = '{8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0};
    tbl[9]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

    do_reset();
    chk_out("reset", 1'b0, 1'b0, 8'h00, 3'd0);
`ifdef RR_ARB_COUNT_EN
    chk("reset.cnt", 32'(gnt_cnt), 32'd0);
`endif

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].rdy, tbl[i].dn);
      chk_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].b,
              tbl[i].oh, tbl[i].ix);
    end

    // full rotation with wrap
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc(8'hFF, 1'b1, 1'b0);
      chk_out($sformatf("rot%0d.offer", k), 1'b1, 1'b0,
              8'(1 << (k % 8)), 3'(k % 8));
      cyc(8'hFF, 1'b1, 1'b0);
      chk($sformatf("rot%0d.busy", k), 32'(busy), 32'd1);
      cyc(8'hFF, 1'b0, 1'b1);
      chk($sformatf("rot%0d.idle", k), 32'(gnt_valid | busy), 32'd0);
    end

    // stall with request dropped; ptr is now 1
    cyc(8'h02, 1'b0, 1'b0);
    chk_out("stall.offer", 1'b1, 1'b0, 8'h02, 3'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 1'b0, 1'b0);
      chk_out($sformatf("stall%0d", k), 1'b1, 1'b0, 8'h02, 3'd1);
    end
    cyc(8'h00, 1'b1, 1'b0);
    chk_out("stall.accept", 1'b0, 1'b1, 8'h02, 3'd1);
    cyc(8'h00, 1'b0, 1'b1);
    chk_out("stall.release", 1'b0, 1'b0, 8'h00, 3'd0);

    // async reset while holding idx 5
    cyc(8'h20, 1'b1, 1'b0);
    chk_out("r5.offer", 1'b1, 1'b0, 8'h20, 3'd5);
    cyc(8'h20, 1'b1, 1'b0);
    chk_out("r5.busy", 1'b0, 1'b1, 8'h20, 3'd5);
    req = 8'h00;
    gnt_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("r5.async", 1'b0, 1'b0, 8'h00, 3'd0);
    #1;
    rst = 1'b0;
    cyc(8'h00, 1'b0, 1'b1);
    chk_out("r5.done_ign", 1'b0, 1'b0, 8'h00, 3'd0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk_out("r5.regrant", 1'b1, 1'b0, 8'h01, 3'd0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk_out("r5.accept", 1'b0, 1'b1, 8'h01, 3'd0);
`ifdef RR_ARB_COUNT_EN
    chk("r5.cnt", 32'(gnt_cnt), 32'd1);
`endif

    // random traffic against model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic rd, d;
      r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 2) == 0);
      model_step(r, rd, d);
      cyc(r, rd, d);
      chk_out($sformatf("rnd%0d", n), m_st == 1, m_st == 2,
              (m_st == 0) ? 8'h00 : 8'(1 << m_idx),
              (m_st == 0) ? 3'd0 : 3'(m_idx));
`ifdef RR_ARB_COUNT_EN
      chk($sformatf("rnd%0d.cnt", n), 32'(gnt_cnt), 32'(m_cnt));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rr_arb8_enc.md
RR_ARB8_ENC -- requirements
Module: rr_arb8_enc

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the grant counter (used only with RR_ARB_COUNT_EN).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req  input  8  SHALL carry per-requester request bits; bit i = requester i.
REQ-005 gnt_ready  input  1  SHALL be the downstream accept for the offered grant.
REQ-006 done  input  1  SHALL be a one-cycle pulse from the granted requester releasing the grant.
REQ-007 gnt_valid  output  1  SHALL be high while a grant is offered.
REQ-008 gnt_onehot  output  8  SHALL be the one-hot grant vector, suitable as input to the 8-to-3 encoder stage.
REQ-009 gnt_idx  output  3  SHALL be the binary index of the granted requester.
REQ-010 busy  output  1  SHALL be high while an accepted grant awaits done.
REQ-011 gnt_cnt  output  CNT_W  SHALL be present only with RR_ARB_COUNT_EN and count accepted grants.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OFFER, BUSY.
REQ-013 IDLE: if req != 0, the block SHALL register the winner and move to OFFER on the next edge (one-cycle latency from req to gnt_valid).
REQ-014 Winner SHALL be the first set req bit scanning ptr, ptr+1, ... ptr+7, modulo 8.
REQ-015 OFFER: gnt_valid=1 and gnt_onehot/gnt_idx SHALL stay stable until gnt_valid && gnt_ready, then go to BUSY.
REQ-016 Deassertion of the granted req bit during OFFER SHALL NOT withdraw the grant.
REQ-017 BUSY: busy=1, gnt_valid=0, and gnt_onehot/gnt_idx SHALL hold the granted value; on done go to IDLE and set ptr = gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-018 done in IDLE or OFFER SHALL be ignored, including when it coincides with gnt_ready in OFFER.
REQ-019 In IDLE, gnt_onehot SHALL be 8'h00 and gnt_idx SHALL be 3'd0.
REQ-020 gnt_onehot SHALL always be zero or exactly one-hot; gnt_onehot[gnt_idx] SHALL be 1 whenever it is nonzero.
REQ-021 New requests arriving in OFFER or BUSY SHALL wait until IDLE; there is no preemption.

Reset
REQ-022 On rst: state=IDLE, ptr=0, gnt_valid=0, busy=0, gnt_onehot=8'h00, gnt_idx=3'd0, gnt_cnt=0.
REQ-023 rst asserted mid-OFFER or mid-BUSY SHALL abort the grant immediately; a later done SHALL be ignored.

Configuration
REQ-024 With RR_ARB_COUNT_EN defined, gnt_cnt SHALL increment by 1 on each OFFER->BUSY transition and wrap at 2^CNT_W.
REQ-025 Without RR_ARB_COUNT_EN, the gnt_cnt port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package rr_arb8_pkg SHALL hold the state enum type (IDLE/OFFER/BUSY), NREQ=8 and IDX_W=3.
REQ-027 Rotating-priority selection SHALL be a sub-module rr_pick8 with inputs req and ptr and outputs onehot, idx and any.

Verification
REQ-028 After reset, req=8'h01, gnt_ready=1 -> gnt_valid is high one cycle later, with gnt_onehot=8'h01, gnt_idx=0, then busy=1.
REQ-029 With req=8'hFF held, done pulsed after each acceptance -> gnt_idx sequence 0,1,2,...,7,0 (wrap checked).
REQ-030 ptr=3 (after a grant to 2), req=8'h05 -> grant goes to idx 0 (8'h01), not 2.
REQ-031 OFFER with gnt_ready=0 for 5 cycles and the req bit dropped -> grant stays stable; it is accepted when gnt_ready=1.
REQ-032 In OFFER, done=1 with gnt_ready=1 -> moves to BUSY; done is ignored; a second done is needed to return to IDLE.
REQ-033 rst pulsed in BUSY with gnt_idx=5 -> all outputs zero, ptr=0; next req=8'hFF -> grant to idx 0; with RR_ARB_COUNT_EN, gnt_cnt=1 after acceptance.
